// File: rtl/ifetch_ctrl_pkg.sv
// Shared instruction-bus types used by the fetch controller and its bus partners.
package ifetch_ctrl_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding bus read per fetch, flush-safe,
// with the completed instruction held in a register until decode accepts it.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter word_t ADEL_INSTR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  addr_t      pc,
    input  logic       stall,
    input  logic       flush,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp,
    output word_t      instr,
    output logic       instr_valid,
    output logic       adel
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DROP} state_t;

    state_t state;
    state_t state_nxt;
    logic   flush_pend;
    logic   cancel;
    logic   cap_addr;
    logic   cap_data;
    logic   cap_adel;
    addr_t  addr_reg;
    word_t  instr_reg;
    logic   adel_reg;

    // A flush seen while the request is still waiting for addr_ok must still
    // cancel the fetch once the bus accepts it.
    assign cancel = flush | flush_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == IDLE)
                flush_pend <= 1'b0;
            else if (state == ADDR && flush)
                flush_pend <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_addr  = 1'b0;
        cap_data  = 1'b0;
        cap_adel  = 1'b0;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (pc[1:0] == 2'b00) begin
                        cap_addr  = 1'b1;
                        state_nxt = ADDR;
                    end else begin
                        cap_adel  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            ADDR: begin
                if (iresp.addr_ok) begin
                    if (iresp.data_ok) begin
                        if (cancel) begin
                            state_nxt = IDLE;
                        end else begin
                            cap_data  = 1'b1;
                            state_nxt = DONE;
                        end
                    end else begin
                        state_nxt = cancel ? DROP : DATA;
                    end
                end
            end
            DATA: begin
                if (iresp.data_ok) begin
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        cap_data  = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (iresp.data_ok)
                    state_nxt = IDLE;
            end
            DONE: begin
                if (!stall || flush)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= '0;
            instr_reg <= '0;
            adel_reg  <= 1'b0;
        end else begin
            if (cap_addr)
                addr_reg <= pc;
            if (cap_data) begin
                instr_reg <= iresp.data;
                adel_reg  <= 1'b0;
            end else if (cap_adel) begin
                instr_reg <= ADEL_INSTR;
                adel_reg  <= 1'b1;
            end
        end
    end

    always_comb begin
        ireq.valid  = (state == ADDR);
        ireq.addr   = addr_reg;
        instr       = instr_reg;
        instr_valid = (state == DONE);
        adel        = adel_reg;
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed transaction table, hand-written corner sequences,
// and randomized transactions scored against a transaction-level outcome model.
module tb_ifetch_ctrl;
    import ifetch_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       flush;
    addr_t      pc;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    word_t      instr;
    logic       instr_valid;
    logic       adel;

    int checks   = 0;
    int failures = 0;

    ifetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .stall       (stall),
        .flush       (flush),
        .ireq        (ireq),
        .iresp       (iresp),
        .instr       (instr),
        .instr_valid (instr_valid),
        .adel        (adel)
    );

    always #5 clk = ~clk;

    // fmode: 0 none, 1 flush on first request cycle, 2 flush on first cycle after addr_ok
    typedef struct {
        addr_t pc;
        word_t data;
        int    ad;
        int    dd;
        int    stall_cyc;
        int    fmode;
        bit    exp_seen;
        word_t exp_instr;
        bit    exp_adel;
        int    exp_lat;
    } txn_t;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Outcome of one fetch: misaligned completes next cycle with adel; any flush
    // hides the fetch; otherwise the word appears one cycle after data_ok.
    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        if (t.pc[1:0] != 2'b00) begin
            r.exp_seen = 1'b1; r.exp_instr = 32'h0; r.exp_adel = 1'b1; r.exp_lat = 1;
        end else if (t.fmode != 0) begin
            r.exp_seen = 1'b0; r.exp_instr = 32'h0; r.exp_adel = 1'b0; r.exp_lat = 0;
        end else begin
            r.exp_seen = 1'b1; r.exp_instr = t.data; r.exp_adel = 1'b0;
            r.exp_lat = t.ad + 1 + t.dd + 1;
        end
        return r;
    endfunction

    // Starts from IDLE held by flush=1; leaves the DUT in IDLE with flush=1.
    task automatic run_txn(input txn_t t, input string tag);
        int    n = 0, vcnt = 0, dcnt = 0, dn = 0, lat = 0;
        bit    accepted = 0, dsent = 0, seen = 0, ending = 0, fin = 0;
        word_t held_i = '0;
        logic  held_a = 1'b0;
        pc    = t.pc;
        flush = 1'b0;
        stall = (t.stall_cyc != 0);
        iresp = '0;
        while (!fin && n < 64) begin
            step();
            n++;
            if (n == 1) pc = $urandom;
            iresp = '0;
            if (!ending) flush = 1'b0;
            if (ending) begin
                checkb({tag, " exit instr_valid"}, instr_valid, 1'b0);
                checkb({tag, " exit ireq.valid"}, ireq.valid, 1'b0);
                fin = 1;
            end else begin
                if (instr_valid) begin
                    if (!seen) begin
                        seen = 1; lat = n; dn = 1;
                        held_i = instr; held_a = adel;
                        check({tag, " instr"}, instr, t.exp_instr);
                        checkb({tag, " adel"}, adel, t.exp_adel);
                        check({tag, " latency"}, lat, t.exp_lat);
                    end else begin
                        dn++;
                        check({tag, " instr held"}, instr, held_i);
                        checkb({tag, " adel held"}, adel, held_a);
                    end
                    if (dn > t.stall_cyc) begin
                        stall = 1'b0; flush = 1'b1; ending = 1;
                    end
                end
                if (ireq.valid) begin
                    vcnt++;
                    check({tag, " ireq.addr"}, ireq.addr, t.pc);
                    checkb({tag, " one outstanding"}, accepted, 1'b0);
                    if (t.fmode == 1 && vcnt == 1) flush = 1'b1;
                    if (vcnt == t.ad + 1) begin
                        iresp.addr_ok = 1'b1;
                        accepted = 1;
                        if (t.dd == 0) begin
                            iresp.data_ok = 1'b1; iresp.data = t.data; dsent = 1;
                        end
                    end
                end else if (accepted && !dsent) begin
                    dcnt++;
                    if (t.fmode == 2 && dcnt == 1) flush = 1'b1;
                    if (dcnt == t.dd) begin
                        iresp.data_ok = 1'b1; iresp.data = t.data; dsent = 1;
                    end
                end
                if (t.fmode != 0 && dsent && !ending) begin
                    flush = 1'b1; ending = 1;
                end
            end
        end
        stall = 1'b0;
        flush = 1'b1;
        iresp = '0;
        checkb({tag, " finished in bound"}, fin, 1'b1);
        checkb({tag, " instr_valid seen"}, seen, t.exp_seen);
        check({tag, " request cycles"}, vcnt, (t.pc[1:0] != 2'b00) ? 0 : t.ad + 1);
    endtask

    txn_t tbl[7];

    initial begin
        reset = 1'b1; flush = 1'b1; stall = 1'b0; pc = '0; iresp = '0;
        step();
        step();
        checkb("reset ireq.valid", ireq.valid, 1'b0);
        check("reset ireq.addr", ireq.addr, 32'h0);
        check("reset instr", instr, 32'h0);
        checkb("reset instr_valid", instr_valid, 1'b0);
        checkb("reset adel", adel, 1'b0);
        reset = 1'b0;
        step();

        tbl[0] = '{pc:32'hbfc0_0000, data:32'h2408_0001, ad:0, dd:0, stall_cyc:0, fmode:0,
                   exp_seen:1, exp_instr:32'h2408_0001, exp_adel:0, exp_lat:2};
        tbl[1] = '{pc:32'hbfc0_0002, data:32'hdead_beef, ad:0, dd:0, stall_cyc:0, fmode:0,
                   exp_seen:1, exp_instr:32'h0, exp_adel:1, exp_lat:1};
        tbl[2] = '{pc:32'hbfc0_0010, data:32'h8c01_0004, ad:3, dd:2, stall_cyc:4, fmode:0,
                   exp_seen:1, exp_instr:32'h8c01_0004, exp_adel:0, exp_lat:7};
        tbl[3] = '{pc:32'hbfc0_0020, data:32'h1111_1111, ad:0, dd:3, stall_cyc:0, fmode:2,
                   exp_seen:0, exp_instr:32'h0, exp_adel:0, exp_lat:0};
        tbl[4] = '{pc:32'hbfc0_0030, data:32'h2222_2222, ad:2, dd:1, stall_cyc:0, fmode:1,
                   exp_seen:0, exp_instr:32'h0, exp_adel:0, exp_lat:0};
        tbl[5] = '{pc:32'h0040_0003, data:32'h5555_5555, ad:0, dd:0, stall_cyc:2, fmode:0,
                   exp_seen:1, exp_instr:32'h0, exp_adel:1, exp_lat:1};
        tbl[6] = '{pc:32'h0040_0100, data:32'h3333_3333, ad:1, dd:0, stall_cyc:1, fmode:0,
                   exp_seen:1, exp_instr:32'h3333_3333, exp_adel:0, exp_lat:3};
        for (int i = 0; i < 7; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));

        // flush overrides stall while an instruction is held
        pc = 32'h0000_1000; flush = 1'b0; stall = 1'b1;
        step();
        checkb("fdone ireq.valid", ireq.valid, 1'b1);
        iresp.addr_ok = 1'b1; iresp.data_ok = 1'b1; iresp.data = 32'h0000_1234;
        step();
        iresp = '0;
        checkb("fdone instr_valid", instr_valid, 1'b1);
        check("fdone instr", instr, 32'h0000_1234);
        flush = 1'b1;
        step();
        checkb("fdone left DONE", instr_valid, 1'b0);
        checkb("fdone no request", ireq.valid, 1'b0);
        stall = 1'b0;

        // reset while waiting in DATA abandons the transaction
        pc = 32'h0000_2000; flush = 1'b0;
        step();
        checkb("rst ireq.valid", ireq.valid, 1'b1);
        iresp.addr_ok = 1'b1;
        step();
        iresp = '0;
        checkb("rst in DATA valid low", ireq.valid, 1'b0);
        reset = 1'b1; flush = 1'b1;
        step();
        checkb("rst ireq.valid", ireq.valid, 1'b0);
        check("rst ireq.addr", ireq.addr, 32'h0);
        check("rst instr", instr, 32'h0);
        checkb("rst instr_valid", instr_valid, 1'b0);
        checkb("rst adel", adel, 1'b0);
        reset = 1'b0;
        step();
        run_txn(model('{pc:32'h0000_3000, data:32'hcafe_f00d, ad:0, dd:1, stall_cyc:0, fmode:0,
                        exp_seen:0, exp_instr:32'h0, exp_adel:0, exp_lat:0}), "after_rst");

        for (int i = 0; i < 40; i++) begin
            txn_t t;
            t.pc = $urandom;
            if ($urandom_range(3) != 0) t.pc[1:0] = 2'b00;
            t.data      = $urandom;
            t.ad        = $urandom_range(3);
            t.dd        = $urandom_range(3);
            t.stall_cyc = $urandom_range(3);
            t.fmode     = (t.pc[1:0] == 2'b00) ? $urandom_range(2) : 0;
            if (t.fmode == 2 && t.dd == 0) t.fmode = 1;
            t.exp_seen = 0; t.exp_instr = '0; t.exp_adel = 0; t.exp_lat = 0;
            run_txn(model(t), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter ADEL_INSTR, default 32'h0000_0000: instruction word reported with an address-error completion.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc  in  32 (addr_t)  fetch address offered by the PC register.
REQ-005 stall  in  1  downstream decode cannot accept the held instruction this cycle.
REQ-006 flush  in  1  cancel current fetch; redirect pending.
REQ-007 ireq  out  ibus_req_t  instruction-bus request (valid, addr).
REQ-008 iresp  in  ibus_resp_t  instruction-bus response (addr_ok, data_ok, data).
REQ-009 instr  out  32 (word_t)  fetched instruction, registered.
REQ-010 instr_valid  out  1  instr/adel hold a completed fetch.
REQ-011 adel  out  1  completed fetch was an address-error (pc[1:0]!=0).

Function
REQ-012 FSM states SHALL be IDLE, ADDR, DATA, DONE, DROP, plus a 1-bit flush_pend register.
REQ-013 IDLE: no flush and pc[1:0]==0 -> latch pc into addr register, go ADDR; no flush and pc misaligned -> set adel, instr=ADEL_INSTR, go DONE without any bus request; flush -> stay IDLE.
REQ-014 ireq.valid SHALL be 1 only in ADDR; ireq.addr SHALL equal the latched addr register and stay stable until addr_ok.
REQ-015 ADDR: once asserted, valid SHALL NOT drop before addr_ok; flush in ADDR sets flush_pend.
REQ-016 ADDR with addr_ok & data_ok: capture data, go DONE; go IDLE instead if flush or flush_pend.
REQ-017 ADDR with addr_ok only: go DATA; go DROP instead if flush or flush_pend.
REQ-018 DATA: flush -> DROP; data_ok -> capture data into instr, adel=0, go DONE (go IDLE if flush same cycle, data discarded).
REQ-019 DROP: wait for data_ok, discard data, go IDLE; flush in DROP has no further effect.
REQ-020 DONE: instr_valid=1; leave to IDLE when !stall or flush; instr/adel held stable while in DONE.
REQ-021 flush_pend SHALL clear on every entry to IDLE.
REQ-022 Minimum latency: pc sampled in IDLE at T, valid at T+1, addr_ok&data_ok at T+1 -> instr_valid at T+2.
REQ-023 At most one bus transaction outstanding at any time.

Reset
REQ-024 reset SHALL force state IDLE, flush_pend=0, ireq.valid=0, ireq.addr=0, instr=0, instr_valid=0, adel=0 at the next edge, in any state.
REQ-025 Reset mid-transaction SHALL abandon it without DROP; the bus is reset by the same signal.

Structure
REQ-026 addr_t, word_t, ibus_req_t, ibus_resp_t SHALL come from the shared common package; the FSM state enum stays local.
REQ-027 No sub-module; single flat module.

Verification
REQ-028 pc=32'hbfc0_0000, addr_ok&data_ok at first valid cycle, data=32'h2408_0001, stall=0 -> valid 1 cycle, instr_valid=1 with instr=32'h2408_0001, adel=0 two cycles after sampling.
REQ-029 pc=32'hbfc0_0002 -> ireq.valid never rises, instr_valid=1, adel=1, instr=32'h0 next cycle.
REQ-030 addr_ok delayed 3 cycles, data_ok 2 more, stall=1 for 4 cycles after -> addr stable during wait, instr held 5 cycles in DONE, IDLE after stall drops.
REQ-031 flush while waiting in DATA, data_ok 2 cycles later -> DROP, returned data never visible, instr_valid stays 0, new fetch starts after IDLE.
REQ-032 flush during ADDR before addr_ok -> valid held until addr_ok, then DROP, data discarded.
REQ-033 reset asserted in DATA -> next cycle all outputs 0, state IDLE.
